// File: rtl/sim_monitor_pkg.sv
// Shared state codes, counter slots and defaults for the simulation end-of-test monitor.
package sim_monitor_pkg;

    localparam int MON_STATE_BUS = 3;

    typedef enum logic [MON_STATE_BUS-1:0] {
        MON_IDLE    = 3'd0,
        MON_RUN     = 3'd1,
        MON_PASS    = 3'd2,
        MON_FAIL    = 3'd3,
        MON_TIMEOUT = 3'd4,
        MON_STALL   = 3'd5
    } mon_state_e;

    localparam int          HOLD_NONE          = 0;
    localparam logic [31:0] MON_TOHOST_DEFAULT = 32'h0000_1000;

    // Slot numbers of the saturating counter bank.
    localparam int CNT_CYC  = 0;
    localparam int CNT_WR   = 1;
    localparam int CNT_JMP  = 2;
    localparam int CNT_HOLD = 3;
    localparam int CNT_NUM  = 4;

    function automatic logic mon_is_terminal(input mon_state_e s);
        return (s == MON_PASS) || (s == MON_FAIL) || (s == MON_TIMEOUT) || (s == MON_STALL);
    endfunction

endpackage

// File: rtl/sim_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/sim_monitor.sv
// End-of-test monitor: watches tohost writes, global cycle budget and pipeline-hold runs,
// and latches a sticky PASS/FAIL/TIMEOUT/STALL verdict with activity counters.
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                REG_ADDR_W  = 5,
    parameter int                HOLD_W      = 3,
    parameter int                CNT_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(MON_TOHOST_DEFAULT),
    parameter int                TIMEOUT_CYC = 1500,
    parameter int                STALL_LIMIT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     reg_we_i,
    input  logic [REG_ADDR_W-1:0]    reg_waddr_i,
    input  logic                     mem_we_i,
    input  logic [ADDR_W-1:0]        mem_waddr_i,
    input  logic [DATA_W-1:0]        mem_wdata_i,
    input  logic                     jump_flag_i,
    input  logic [HOLD_W-1:0]        hold_flag_i,
    output logic [MON_STATE_BUS-1:0] state_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic [DATA_W-2:0]        test_num_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [CNT_W-1:0]         wr_cnt_o,
    output logic [CNT_W-1:0]         jump_cnt_o
);

    mon_state_e         r_state;
    mon_state_e         w_state_next;
    logic               r_done, r_pass, r_fail, r_timeout;
    logic               w_done_next, w_pass_next, w_fail_next, w_timeout_next;
    logic [DATA_W-2:0]  r_test_num;
    logic [DATA_W-2:0]  w_test_num_next;

    logic               w_run;
    logic               w_hold_active;
    logic               w_tohost;
    logic               w_tohost_pass;
    logic               w_stall_hit;
    logic               w_tmo_hit;

    logic [CNT_NUM-1:0] w_inc;
    logic [CNT_NUM-1:0] w_clr;
    logic [CNT_W-1:0]   w_cnt [CNT_NUM];

    assign w_run         = (r_state == MON_RUN);
    assign w_hold_active = (hold_flag_i != HOLD_W'(HOLD_NONE));
    assign w_tohost      = mem_we_i && (mem_waddr_i == TOHOST_ADDR) && mem_wdata_i[0];
    assign w_tohost_pass = (mem_wdata_i == DATA_W'(1));

    assign w_inc[CNT_CYC]  = w_run;
    assign w_inc[CNT_WR]   = w_run && reg_we_i && (reg_waddr_i != '0);
    assign w_inc[CNT_JMP]  = w_run && jump_flag_i;
    assign w_inc[CNT_HOLD] = w_run && w_hold_active;

    // Only the hold counter measures a run; the others clear solely through rst.
    assign w_clr[CNT_CYC]  = 1'b0;
    assign w_clr[CNT_WR]   = 1'b0;
    assign w_clr[CNT_JMP]  = 1'b0;
    assign w_clr[CNT_HOLD] = w_run && !w_hold_active;

    generate
        for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
            sat_counter #(
                .W     (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr_i (w_clr[gi]),
                .inc_i (w_inc[gi]),
                .cnt_o (w_cnt[gi])
            );
        end
    endgenerate

    // Limits are judged on the count this edge produces, so compare against limit-1.
    assign w_stall_hit = w_inc[CNT_HOLD] && (w_cnt[CNT_HOLD] >= CNT_W'(STALL_LIMIT - 1));
    assign w_tmo_hit   = (w_cnt[CNT_CYC] >= CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= MON_IDLE;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_test_num <= '0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= w_done_next;
            r_pass     <= w_pass_next;
            r_fail     <= w_fail_next;
            r_timeout  <= w_timeout_next;
            r_test_num <= w_test_num_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MON_IDLE: begin
                if (en_i) begin
                    w_state_next = MON_RUN;
                end
            end
            MON_RUN: begin
                if (w_tohost) begin
                    w_state_next = w_tohost_pass ? MON_PASS : MON_FAIL;
                end else if (w_stall_hit) begin
                    w_state_next = MON_STALL;
                end else if (w_tmo_hit) begin
                    w_state_next = MON_TIMEOUT;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_comb begin
        w_done_next     = mon_is_terminal(w_state_next);
        w_pass_next     = (w_state_next == MON_PASS);
        w_fail_next     = (w_state_next == MON_FAIL);
        w_timeout_next  = (w_state_next == MON_TIMEOUT) || (w_state_next == MON_STALL);
        w_test_num_next = r_test_num;
        if (w_run && w_tohost && !w_tohost_pass) begin
            w_test_num_next = mem_wdata_i[DATA_W-1:1];
        end
    end

    assign state_o     = r_state;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign timeout_o   = r_timeout;
    assign test_num_o  = r_test_num;
    assign cycle_cnt_o = w_cnt[CNT_CYC];
    assign wr_cnt_o    = w_cnt[CNT_WR];
    assign jump_cnt_o  = w_cnt[CNT_JMP];

endmodule

// File: tb/tb_sim_monitor.sv
// Directed and randomized check of sim_monitor (two instances: short and default timeout).
module tb_sim_monitor;

    localparam int          N_DUT  = 2;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam int          STALL  = 64;
    localparam int          S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3, S_TMO = 4, S_STALL = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_waddr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        jump_flag_i = 1'b0;
    logic [2:0]  hold_flag_i = '0;

    logic [2:0]  o_state   [N_DUT];
    logic        o_done    [N_DUT];
    logic        o_pass    [N_DUT];
    logic        o_fail    [N_DUT];
    logic        o_timeout [N_DUT];
    logic [30:0] o_tnum    [N_DUT];
    logic [31:0] o_cyc     [N_DUT];
    logic [31:0] o_wr      [N_DUT];
    logic [31:0] o_jmp     [N_DUT];

    int          tmo_cfg [N_DUT] = '{20, 1500};

    // Reference model state, one per instance.
    int          m_state [N_DUT];
    logic [31:0] m_cyc   [N_DUT];
    logic [31:0] m_wr    [N_DUT];
    logic [31:0] m_jmp   [N_DUT];
    logic [31:0] m_hold  [N_DUT];
    logic [30:0] m_tnum  [N_DUT];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sim_monitor #(.TIMEOUT_CYC(20)) dut_t (
        .clk(clk), .rst(rst), .en_i(en_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
        .state_o(o_state[0]), .done_o(o_done[0]), .pass_o(o_pass[0]), .fail_o(o_fail[0]),
        .timeout_o(o_timeout[0]), .test_num_o(o_tnum[0]), .cycle_cnt_o(o_cyc[0]),
        .wr_cnt_o(o_wr[0]), .jump_cnt_o(o_jmp[0])
    );

    sim_monitor dut_d (
        .clk(clk), .rst(rst), .en_i(en_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
        .state_o(o_state[1]), .done_o(o_done[1]), .pass_o(o_pass[1]), .fail_o(o_fail[1]),
        .timeout_o(o_timeout[1]), .test_num_o(o_tnum[1]), .cycle_cnt_o(o_cyc[1]),
        .wr_cnt_o(o_wr[1]), .jump_cnt_o(o_jmp[1])
    );

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            m_state[i] = S_IDLE;
            m_cyc[i] = '0; m_wr[i] = '0; m_jmp[i] = '0; m_hold[i] = '0; m_tnum[i] = '0;
        end
    endtask

    // Verdict rules: tohost write wins; otherwise a hold run or the cycle total reaching its limit.
    task automatic model_step();
        logic        th;
        logic [31:0] cyc_after, hold_after;
        for (int i = 0; i < N_DUT; i++) begin
            if (m_state[i] == S_IDLE) begin
                if (en_i) m_state[i] = S_RUN;
            end else if (m_state[i] == S_RUN) begin
                th         = mem_we_i && (mem_waddr_i == TOHOST) && mem_wdata_i[0];
                hold_after = (hold_flag_i != 0) ? sat_inc(m_hold[i]) : 32'd0;
                cyc_after  = sat_inc(m_cyc[i]);
                m_cyc[i]   = cyc_after;
                m_hold[i]  = hold_after;
                if (reg_we_i && reg_waddr_i != 0) m_wr[i] = sat_inc(m_wr[i]);
                if (jump_flag_i) m_jmp[i] = sat_inc(m_jmp[i]);
                if (th) begin
                    if (mem_wdata_i == 32'd1) m_state[i] = S_PASS;
                    else begin
                        m_state[i] = S_FAIL;
                        m_tnum[i]  = 31'(mem_wdata_i >> 1);
                    end
                end else if (hold_after >= STALL) m_state[i] = S_STALL;
                else if (cyc_after >= 32'(tmo_cfg[i])) m_state[i] = S_TMO;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("state[%0d]", i),   32'(o_state[i]),   32'(m_state[i]));
            chk($sformatf("done[%0d]", i),    32'(o_done[i]),    32'(m_state[i] >= S_PASS));
            chk($sformatf("pass[%0d]", i),    32'(o_pass[i]),    32'(m_state[i] == S_PASS));
            chk($sformatf("fail[%0d]", i),    32'(o_fail[i]),    32'(m_state[i] == S_FAIL));
            chk($sformatf("timeout[%0d]", i), 32'(o_timeout[i]), 32'(m_state[i] == S_TMO || m_state[i] == S_STALL));
            chk($sformatf("test_num[%0d]", i), 32'(o_tnum[i]),   32'(m_tnum[i]));
            chk($sformatf("cycle_cnt[%0d]", i), o_cyc[i], m_cyc[i]);
            chk($sformatf("wr_cnt[%0d]", i),    o_wr[i],  m_wr[i]);
            chk($sformatf("jump_cnt[%0d]", i),  o_jmp[i], m_jmp[i]);
        end
    endtask

    task automatic idle_inputs();
        en_i = 0; reg_we_i = 0; reg_waddr_i = '0; mem_we_i = 0; mem_waddr_i = '0;
        mem_wdata_i = '0; jump_flag_i = 0; hold_flag_i = '0;
    endtask

    // Inputs are set just after a falling edge; the model advances at the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        idle_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run();
        en_i = 1'b1;
        tick();
    endtask

    task automatic tohost_write(input logic [31:0] data);
        mem_we_i = 1'b1; mem_waddr_i = TOHOST; mem_wdata_i = data;
        tick();
        $display("tohost write data=0x%0h -> state t=%0d d=%0d", data, o_state[0], o_state[1]);
    endtask

    initial begin
        // T1: pass after ten idle RUN cycles
        do_reset();
        chk("reset_state", 32'(o_state[1]), 32'd0);
        chk("reset_done",  32'(o_done[1]),  32'd0);
        start_run();
        for (int k = 0; k < 10; k++) tick();
        tohost_write(32'd1);
        chk("t1_pass",  32'(o_pass[1]), 32'd1);
        chk("t1_done",  32'(o_done[1]), 32'd1);
        chk("t1_cycle", o_cyc[1], 32'd11);

        // T2: fail with test number, then sticky
        do_reset();
        start_run();
        tohost_write(32'h7);
        chk("t2_fail", 32'(o_fail[1]), 32'd1);
        chk("t2_tnum", 32'(o_tnum[1]), 32'd3);
        tohost_write(32'h1);
        chk("t2_sticky", 32'(o_state[1]), 32'(S_FAIL));
        chk("t2_nopass", 32'(o_pass[1]),  32'd0);

        // T3: timeout at 20 cycles, counter frozen afterwards
        do_reset();
        start_run();
        for (int k = 0; k < 19; k++) tick();
        chk("t3_pre_tmo", 32'(o_timeout[0]), 32'd0);
        for (int k = 0; k < 6; k++) tick();
        chk("t3_timeout", 32'(o_timeout[0]), 32'd1);
        chk("t3_state",   32'(o_state[0]),   32'(S_TMO));
        chk("t3_cycle",   o_cyc[0],          32'd20);
        $display("timeout run: cycle_cnt=%0d", o_cyc[0]);

        // T4: 63 holds, one gap, then 64 holds
        do_reset();
        start_run();
        for (int k = 0; k < 63; k++) begin hold_flag_i = 3'd1; tick(); end
        chk("t4_no_stall", 32'(o_state[1]), 32'(S_RUN));
        tick();
        for (int k = 0; k < 63; k++) begin hold_flag_i = 3'd4; tick(); end
        chk("t4_still_run", 32'(o_state[1]), 32'(S_RUN));
        hold_flag_i = 3'd2;
        tick();
        chk("t4_stall",   32'(o_state[1]),   32'(S_STALL));
        chk("t4_timeout", 32'(o_timeout[1]), 32'd1);
        $display("stall run: state=%0d cycle_cnt=%0d", o_state[1], o_cyc[1]);

        // T5: tohost pass on the timeout edge wins
        do_reset();
        start_run();
        for (int k = 0; k < 19; k++) tick();
        tohost_write(32'd1);
        chk("t5_pass",    32'(o_pass[0]),    32'd1);
        chk("t5_notmo",   32'(o_timeout[0]), 32'd0);
        chk("t5_cycle",   o_cyc[0],          32'd20);

        // T6: x0 writes ignored, reset mid-RUN clears everything
        do_reset();
        start_run();
        reg_we_i = 1; reg_waddr_i = 5'd0; tick();
        reg_we_i = 1; reg_waddr_i = 5'd5; tick();
        reg_we_i = 1; reg_waddr_i = 5'd5; tick();
        chk("t6_wr", o_wr[1], 32'd2);
        do_reset();
        chk("t6_idle",   32'(o_state[1]), 32'(S_IDLE));
        chk("t6_wr_clr", o_wr[1],         32'd0);

        // Randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int k = 0; k < 3; k++) tick();
            start_run();
            for (int k = 0; k < 70; k++) begin
                en_i        = 1'($urandom_range(0, 1));
                reg_we_i    = 1'($urandom_range(0, 1));
                reg_waddr_i = 5'($urandom_range(0, 31));
                jump_flag_i = 1'($urandom_range(0, 1));
                hold_flag_i = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
                mem_we_i    = ($urandom_range(0, 15) == 0);
                mem_waddr_i = ($urandom_range(0, 1) == 0) ? TOHOST : TOHOST + 32'($urandom_range(1, 8) * 4);
                case ($urandom_range(0, 3))
                    0:       mem_wdata_i = 32'd1;
                    1:       mem_wdata_i = $urandom | 32'd1;
                    2:       mem_wdata_i = $urandom & ~32'd1;
                    default: mem_wdata_i = 32'd7;
                endcase
                tick();
            end
            $display("random run %0d: state t=%0d d=%0d cycle=%0d wr=%0d jmp=%0d",
                     r, o_state[0], o_state[1], o_cyc[1], o_wr[1], o_jmp[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
